rev_serial_alu: RTL
===================

Name: rev_serial_alu

Overview:
- Parametrised, multi-cycle successor to the 1-bit reversible ALU slice.
- Processes a WIDTH-bit operand pair DIGIT bits per clock through a reversible-style full-adder/logic cell, with valid/ready handshakes on both sides.
- The per-digit adder cell is functionally equivalent to a DPG chain: sum = a^b^cin, cout = ((a^b)&cin)^(a&b).
- Sits between the operand register file and the result writeback stage of the 16-bit ALU.

Parameters:
- WIDTH, 16: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1: bits processed per RUN cycle; legal values 1, 2, 4, 8 with WIDTH % DIGIT == 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 NAND, 111 NOR.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  computed result.
- carry  output  1  carry out (ADD) or no-borrow (SUB); 0 for logic ops.
- overflow  output  1  signed overflow for ADD/SUB; 0 for logic ops.
- zero  output  1  result == 0, all ops.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst is sampled only on the rising clk edge.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, carry=0, overflow=0, zero=0, internal digit counter=0, carry register=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a, b and op into shift registers and go to RUN.
  - Initial carry is 1 for SUB, else 0.
  - For SUB, B is inverted as it is latched (A + ~B + 1).
- RUN:
  - in_ready=0.
  - Each edge processes the lowest DIGIT bits of the operand shift registers, shifts the result register right by DIGIT with the new digit entering at the top, and ripples the carry internally across the DIGIT cells.
  - The counter increments per edge.
  - After WIDTH/DIGIT edges, go to DONE.
- Capture on the final RUN edge:
  - Final carry into carry.
  - overflow = carry-in to MSB XOR carry-out of MSB, for ADD/SUB only.
  - zero from the full result.
- Logic ops use the same digit datapath with the carry chain forced to 0. For these ops, carry and overflow are 0.
- DONE:
  - out_valid=1; result and flags are held stable.
  - On an edge with out_ready=1, go to IDLE; out_valid drops after that edge.
  - No new operation is accepted in DONE, even if out_ready=1.
- Latency: out_valid rises WIDTH/DIGIT edges after the accepting edge (16 for defaults). Minimum issue interval is WIDTH/DIGIT+2 cycles.
- Operand and op inputs are ignored outside the accepting edge. Changes during RUN/DONE have no effect.
- result and flags hold their last values in IDLE until the next DONE; consumers qualify them with out_valid.
- Reset during RUN or DONE:
  - Abort immediately and return to IDLE with reset values; the in-flight result is discarded.
  - Reset wins over a simultaneous in_valid or out_ready.
- The counter wraps only by returning to 0 on leaving RUN. It never exceeds WIDTH/DIGIT-1.

Test Plan:
- Defaults; ADD a=0xFFFF b=0x0001, accept on edge E0 -> out_valid high after E16; result=0x0000, carry=1, zero=1, overflow=0; busy high from E1 until the out handshake.
- SUB a=0x8000 b=0x0001 -> result=0x7FFF, carry=1, overflow=1, zero=0. Then SUB a=0x0003 b=0x0005 -> result=0xFFFE, carry=0, overflow=0.
- ADD a=0x7FFF b=0x0001 -> result=0x8000, overflow=1, carry=0. XOR a=0xA5A5 b=0xA5A5 -> result=0x0000, zero=1, carry=0, overflow=0. NOR a=0x00FF b=0x0F00 -> result=0xF000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and changing a/b -> result/flags stable, in_ready=0, no new accept; out_ready=1 -> IDLE the next cycle, then the new op is accepted.
- Assert rst on the 7th RUN cycle of ADD 0x1234+0x1111 -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; a following ADD 0x1234+0x1111 -> 0x2345 after 16 edges.
- WIDTH=16, DIGIT=4: ADD 0x0FFF+0x0001 -> result=0x1000, out_valid 4 edges after accept; random 1000-op run against a reference model at DIGIT=1, 2, 4, 8.

Source files
------------

// File: rtl/rev_serial_alu.sv
// rtl/rev_serial_alu.sv - digit-serial reversible-style ALU with valid/ready handshakes
//
// Purpose: computes ADD/SUB/logic ops on a WIDTH-bit operand pair, DIGIT bits per
// clock, using a DPG-style full-adder cell (sum = a^b^cin, cout = ((a^b)&cin)^(a&b)).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake (accepted only in IDLE)
//   a, b, op            operands and opcode (000 ADD .. 111 NOR)
//   out_valid, out_ready result handshake (held in DONE until out_ready)
//   result              WIDTH-bit result
//   carry, overflow     carry/no-borrow and signed overflow (ADD/SUB only)
//   zero                result == 0
//   busy                high in RUN or DONE

module rev_serial_alu #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             busy
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NAND = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [2:0]         op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cy_q, cy_d;
   logic               carry_q, carry_d;
   logic               overflow_q, overflow_d;
   logic               zero_q, zero_d;

   logic               arith;
   logic [DIGIT-1:0]   dig;
   logic               chain;
   logic               cy_msb_in;
   logic               p;
   logic               g;

   assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

   // One digit of DPG cells. The carry chain is seeded with 0 for logic ops so
   // the flags derived from it stay 0. cy_msb_in ends up holding the carry into
   // the top cell of the digit, which on the final digit is the operand MSB.
   always_comb begin
      dig       = '0;
      chain     = cy_q & arith;
      cy_msb_in = 1'b0;
      p         = 1'b0;
      g         = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         cy_msb_in = chain;
         p = a_q[i] ^ b_q[i];
         g = a_q[i] & b_q[i];
         case (op_q)
            OP_ADD, OP_SUB: begin
               dig[i] = p ^ chain;
               chain  = (p & chain) ^ g;
            end
            OP_AND:  dig[i] = g;
            OP_OR:   dig[i] = a_q[i] | b_q[i];
            OP_XOR:  dig[i] = p;
            OP_XNOR: dig[i] = ~p;
            OP_NAND: dig[i] = ~g;
            default: dig[i] = ~(a_q[i] | b_q[i]);
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sh_d       = sh_q;
      result_d   = result_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      cy_d       = cy_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
               b_d     = (op == OP_SUB) ? ~b : b;
               op_d    = op;
               cy_d    = (op == OP_SUB);
               cnt_d   = '0;
               sh_d    = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            a_d  = a_q >> DIGIT;
            b_d  = b_q >> DIGIT;
            sh_d = (sh_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
            cy_d = chain;
            if (cnt_q == CNT_W'(NDIG - 1)) begin
               cnt_d      = '0;
               cy_d       = 1'b0;
               result_d   = sh_d;
               carry_d    = arith & chain;
               overflow_d = arith & (cy_msb_in ^ chain);
               zero_d     = (sh_d == '0);
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sh_q       <= '0;
         result_q   <= '0;
         op_q       <= '0;
         cnt_q      <= '0;
         cy_q       <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sh_q       <= sh_d;
         result_q   <= result_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         cy_q       <= cy_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign result    = result_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;

endmodule
